// File: rtl/t_seq_packer_if.sv
// T-sequence load port between the host-side packer and its peers.
//   i_seq_start    : 1-cycle pulse, begin a new sequence
//   i_ch_valid/i_ch/i_ch_last / o_ch_ready : per-nucleotide handshake
//   i_ctrl_busy    : SRAM controller busy flag
//   o_start_read_t : 1-cycle pulse carrying the first word on o_t
//   o_t            : 18-bit word {valid, cnt[2:0], c0..c6}
//   o_done         : pulse with the last word of a sequence
//   o_overflow     : sticky, chars dropped at capacity
interface t_seq_packer_if;
  logic        i_seq_start;
  logic        i_ch_valid;
  logic [1:0]  i_ch;
  logic        i_ch_last;
  logic        o_ch_ready;
  logic        i_ctrl_busy;
  logic        o_start_read_t;
  logic [17:0] o_t;
  logic        o_done;
  logic        o_overflow;

  modport master (
    output i_seq_start, i_ch_valid, i_ch, i_ch_last, i_ctrl_busy,
    input  o_ch_ready, o_start_read_t, o_t, o_done, o_overflow
  );

  modport slave (
    input  i_seq_start, i_ch_valid, i_ch, i_ch_last, i_ctrl_busy,
    output o_ch_ready, o_start_read_t, o_t, o_done, o_overflow
  );
endinterface

// File: rtl/t_seq_packer.sv
// Host-side transmitter for the SRAM controller's T-sequence load port.
// Packs 2-bit nucleotides 7 per 18-bit word {valid, cnt[2:0], c0..c6}
// (c0 at [13:12]); cnt=0 marks a full word with more to follow, cnt=1..7
// marks the last word. The first word is held until the controller is idle
// and sent with o_start_read_t; following words stream one per cycle.
// Ports: clk, rst_n (async, active-low), bus (t_seq_packer_if.slave).
module t_seq_packer #(
  parameter int unsigned T_PER_WORD = 7,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned WCNT_W     = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  t_seq_packer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARM,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ccnt_q, ccnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [13:0]        chars_q, chars_d;
  logic [17:0]        word_q, word_d;
  logic               word_last_q, word_last_d;
  logic               word_ovf_q, word_ovf_d;
  logic [17:0]        t_q, t_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               rdy_q, rdy_d;

  logic        accept;
  logic        full;
  logic        at_cap;
  logic        word_end;
  logic        seq_end;
  logic        forced;
  logic [13:0] chars_ins;
  logic [2:0]  cnt_fld;
  logic [17:0] new_word;

  // Char-slot insertion and word assembly for the char being accepted.
  always_comb begin
    chars_ins = chars_q;
    for (int unsigned i = 0; i < T_PER_WORD; i++) begin
      if (ccnt_q == 3'(i)) chars_ins[13 - 2*i -: 2] = bus.i_ch;
    end
    accept   = bus.i_ch_valid & rdy_q;
    full     = (ccnt_q == 3'(T_PER_WORD - 1));
    at_cap   = (wcnt_q == WCNT_W'(MAX_WORDS - 1));
    word_end = full | bus.i_ch_last;
    // A full word at the last store index ends the sequence even without
    // i_ch_last; the remainder of the sequence is then dropped.
    seq_end  = bus.i_ch_last | (full & at_cap);
    forced   = full & at_cap & ~bus.i_ch_last;
    cnt_fld  = seq_end ? ccnt_q + 3'd1 : 3'd0;
    new_word = {1'b1, cnt_fld, chars_ins};
  end

  always_comb begin
    state_d     = state_q;
    ccnt_d      = ccnt_q;
    wcnt_d      = wcnt_q;
    chars_d     = chars_q;
    word_d      = word_q;
    word_last_d = word_last_q;
    word_ovf_d  = word_ovf_q;
    t_d         = '0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_seq_start) begin
          state_d = S_FILL;
          ccnt_d  = '0;
          wcnt_d  = '0;
          chars_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_FILL: begin
        if (accept) begin
          chars_d = chars_ins;
          ccnt_d  = ccnt_q + 3'd1;
          if (word_end) begin
            word_d      = new_word;
            word_last_d = seq_end;
            word_ovf_d  = forced;
            ccnt_d      = '0;
            chars_d     = '0;
            state_d     = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (!bus.i_ctrl_busy) begin
          t_d     = word_q;
          start_d = 1'b1;
          wcnt_d  = wcnt_q + 1'b1;
          if (word_last_q) begin
            done_d  = 1'b1;
            ovf_d   = ovf_q | word_ovf_q;
            state_d = word_ovf_q ? S_DRAIN : S_IDLE;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          chars_d = chars_ins;
          ccnt_d  = ccnt_q + 3'd1;
          if (word_end) begin
            t_d     = new_word;
            wcnt_d  = wcnt_q + 1'b1;
            ccnt_d  = '0;
            chars_d = '0;
            if (seq_end) begin
              done_d  = 1'b1;
              ovf_d   = ovf_q | forced;
              state_d = forced ? S_DRAIN : S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        if (accept && bus.i_ch_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered, so it follows the state being entered.
    rdy_d = (state_d == S_FILL) || (state_d == S_STREAM) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ccnt_q      <= '0;
      wcnt_q      <= '0;
      chars_q     <= '0;
      word_q      <= '0;
      word_last_q <= 1'b0;
      word_ovf_q  <= 1'b0;
      t_q         <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ccnt_q      <= ccnt_d;
      wcnt_q      <= wcnt_d;
      chars_q     <= chars_d;
      word_q      <= word_d;
      word_last_q <= word_last_d;
      word_ovf_q  <= word_ovf_d;
      t_q         <= t_d;
      start_q     <= start_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      rdy_q       <= rdy_d;
    end
  end

  assign bus.o_ch_ready     = rdy_q;
  assign bus.o_start_read_t = start_q;
  assign bus.o_t            = t_q;
  assign bus.o_done         = done_q;
  assign bus.o_overflow     = ovf_q;

endmodule
